dmem_lsu: RTL and testbench



---
 rtl/swt16_lsu_pkg.sv | 10 +
 rtl/dmem_lsu_byte_fmt.sv | 22 ++
 rtl/dmem_lsu.sv | 130 +++++++++++++
 tb/tb_dmem_lsu.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/swt16_lsu_pkg.sv
// swt16_lsu_pkg: FSM states and byte-lane constants shared by the dmem_lsu files.
package swt16_lsu_pkg;

    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_DATA, WR} state_t;

    localparam int   BYTE_WIDTH = 8;
    localparam logic LANE_LO    = 1'b0;
    localparam logic LANE_HI    = 1'b1;

endpackage

// File: rtl/dmem_lsu_byte_fmt.sv
// dmem_lsu_byte_fmt: byte-lane extract/extend for loads and lane merge for byte stores.
module dmem_lsu_byte_fmt
    import swt16_lsu_pkg::*;
(
    input  logic [2*BYTE_WIDTH-1:0] mem_word,
    input  logic                    lane,
    input  logic                    sgn,
    input  logic [BYTE_WIDTH-1:0]   st_byte,
    output logic [2*BYTE_WIDTH-1:0] ld_word,
    output logic [2*BYTE_WIDTH-1:0] st_word
);

    logic [BYTE_WIDTH-1:0] sel;

    always_comb begin
        sel     = (lane == LANE_HI) ? mem_word[2*BYTE_WIDTH-1:BYTE_WIDTH] : mem_word[BYTE_WIDTH-1:0];
        ld_word = {{BYTE_WIDTH{sgn & sel[BYTE_WIDTH-1]}}, sel};
        st_word = (lane == LANE_HI) ? {st_byte, mem_word[BYTE_WIDTH-1:0]}
                                    : {mem_word[2*BYTE_WIDTH-1:BYTE_WIDTH], st_byte};
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit in front of a word-only data memory, adding byte access.
// Define DMEM_LSU_MISALIGN_TRAP_EN to trap word accesses with addr[0]=1 instead of aligning them.
module dmem_lsu #(
    parameter int WORD_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_req,
    input  logic                  in_we,
    input  logic                  in_byte,
    input  logic                  in_signed,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [WORD_WIDTH-1:0] in_wdata,
    output logic                  out_ready,
    output logic                  out_done,
    output logic [WORD_WIDTH-1:0] out_rdata,
    output logic                  out_err,
    output logic [ADDR_WIDTH-1:0] out_mem_addr_rd,
    output logic [ADDR_WIDTH-1:0] out_mem_addr_wr,
    output logic [WORD_WIDTH-1:0] out_mem_word,
    output logic                  out_mem_we,
    input  logic [WORD_WIDTH-1:0] in_mem_word
);

    import swt16_lsu_pkg::*;

    state_t                state_q, state_d;
    logic                  we_q, we_d, byte_q, byte_d, sgn_q, sgn_d, lane_q, lane_d;
    logic                  err_q, err_d, mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] addr_rd_q, addr_rd_d, addr_wr_q, addr_wr_d, aligned;
    logic [WORD_WIDTH-1:0] mem_word_q, mem_word_d, ld_word, st_word;
    logic                  mis;

    // mem_word_q doubles as the store-data holder: its low byte feeds the merge
    dmem_lsu_byte_fmt u_fmt (
        .mem_word (in_mem_word),
        .lane     (lane_q),
        .sgn      (sgn_q),
        .st_byte  (mem_word_q[BYTE_WIDTH-1:0]),
        .ld_word  (ld_word),
        .st_word  (st_word)
    );

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        byte_d     = byte_q;
        sgn_d      = sgn_q;
        lane_d     = lane_q;
        err_d      = err_q;
        mem_we_d   = 1'b0;
        addr_rd_d  = addr_rd_q;
        addr_wr_d  = addr_wr_q;
        mem_word_d = mem_word_q;
        aligned    = {in_addr[ADDR_WIDTH-1:1], 1'b0};
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        mis        = ~in_byte & in_addr[0];
`else
        mis        = 1'b0;
`endif
        case (state_q)
            IDLE: if (in_req) begin
                we_d       = in_we;
                byte_d     = in_byte;
                sgn_d      = in_signed;
                lane_d     = in_addr[0];
                err_d      = mis;
                mem_word_d = in_wdata;
                if (mis) begin
                    state_d = WR;
                end else if (in_we & ~in_byte) begin
                    state_d   = WR;
                    mem_we_d  = 1'b1;
                    addr_wr_d = aligned;
                end else begin
                    state_d   = RD_ADDR;
                    addr_rd_d = aligned;
                    addr_wr_d = in_we ? aligned : addr_wr_q;
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                state_d    = we_q ? WR : IDLE;
                mem_we_d   = we_q;
                mem_word_d = we_q ? st_word : mem_word_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            sgn_q      <= 1'b0;
            lane_q     <= 1'b0;
            err_q      <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_rd_q  <= '0;
            addr_wr_q  <= '0;
            mem_word_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            sgn_q      <= sgn_d;
            lane_q     <= lane_d;
            err_q      <= err_d;
            mem_we_q   <= mem_we_d;
            addr_rd_q  <= addr_rd_d;
            addr_wr_q  <= addr_wr_d;
            mem_word_q <= mem_word_d;
        end
    end

    always_comb begin
        out_ready       = state_q == IDLE;
        out_done        = (state_q == WR) | ((state_q == RD_DATA) & ~we_q);
        out_rdata       = ((state_q == RD_DATA) & ~we_q) ? (byte_q ? ld_word : in_mem_word) : '0;
        out_err         = (state_q == WR) & err_q;
        out_mem_addr_rd = addr_rd_q;
        out_mem_addr_wr = addr_wr_q;
        out_mem_word    = mem_word_q;
        out_mem_we      = mem_we_q;
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed scoreboard bench for dmem_lsu with a behavioural word memory.
module tb_dmem_lsu;

    logic        clock = 1'b0, reset = 1'b1;
    logic        in_req = 1'b0, in_we = 1'b0, in_byte = 1'b0, in_signed = 1'b0;
    logic [11:0] in_addr = '0;
    logic [15:0] in_wdata = '0, in_mem_word = '0;
    logic        out_ready, out_done, out_err, out_mem_we;
    logic [15:0] out_rdata, out_mem_word;
    logic [11:0] out_mem_addr_rd, out_mem_addr_wr;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          cyc0;
        logic        chkw;
        logic [15:0] wword;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] mem [0:2047];
    int          cyc = 0, total = 0, bad = 0;
    logic        watch = 1'b0, we_seen = 1'b0;

    dmem_lsu dut (
        .clock(clock), .reset(reset), .in_req(in_req), .in_we(in_we), .in_byte(in_byte),
        .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata), .out_ready(out_ready),
        .out_done(out_done), .out_rdata(out_rdata), .out_err(out_err),
        .out_mem_addr_rd(out_mem_addr_rd), .out_mem_addr_wr(out_mem_addr_wr),
        .out_mem_word(out_mem_word), .out_mem_we(out_mem_we), .in_mem_word(in_mem_word)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (out_mem_we) mem[out_mem_addr_wr[11:1]] <= out_mem_word;
        in_mem_word <= mem[out_mem_addr_rd[11:1]];
        if (watch && out_mem_we) we_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (out_done) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("latency", cyc - e.cyc0, e.lat);
                chk("rdata", out_rdata, e.rdata);
                chk("err", out_err, e.err);
                chk("mem_we", out_mem_we, e.chkw);
                if (e.chkw) chk("mem_word", out_mem_word, e.wword);
            end
        end else chk("rdata_idle", out_rdata, 0);
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clock);
        while (!out_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_timeout", out_ready, 1);
    endtask

    task automatic issue(input logic we, input logic byt, input logic sgn, input logic [11:0] a,
                         input logic [15:0] wd, input logic [15:0] er, input logic ee,
                         input int lat, input logic cw, input logic [15:0] ww);
        wait_ready();
        in_req = 1'b1; in_we = we; in_byte = byt; in_signed = sgn; in_addr = a; in_wdata = wd;
        sb.push_back('{er, ee, lat, cyc, cw, ww});
        @(negedge clock);
        in_req = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_ready", out_ready, 1);
        chk("rst_done", out_done, 0);
        chk("rst_err", out_err, 0);
        chk("rst_we", out_mem_we, 0);
        chk("rst_addr_rd", out_mem_addr_rd, 0);
        chk("rst_addr_wr", out_mem_addr_wr, 0);
        chk("rst_word", out_mem_word, 0);
        reset = 1'b0;
        issue(1, 0, 0, 12'h010, 16'hBEEF, 16'h0000, 0, 1, 1, 16'hBEEF);
        issue(0, 0, 0, 12'h010, 16'h0000, 16'hBEEF, 0, 2, 0, 16'h0000);
        issue(1, 0, 0, 12'h020, 16'h80F7, 16'h0000, 0, 1, 1, 16'h80F7);
        issue(0, 1, 1, 12'h020, 16'h0000, 16'hFFF7, 0, 2, 0, 16'h0000);
        issue(0, 1, 1, 12'h021, 16'h0000, 16'hFF80, 0, 2, 0, 16'h0000);
        issue(0, 1, 0, 12'h021, 16'h0000, 16'h0080, 0, 2, 0, 16'h0000);
        issue(0, 1, 0, 12'h020, 16'h0000, 16'h00F7, 0, 2, 0, 16'h0000);
        issue(1, 0, 0, 12'h030, 16'h1234, 16'h0000, 0, 1, 1, 16'h1234);
        issue(1, 1, 0, 12'h031, 16'h55AB, 16'h0000, 0, 3, 1, 16'hAB34);
        issue(1, 1, 0, 12'h030, 16'h77CD, 16'h0000, 0, 3, 1, 16'hABCD);
        issue(0, 0, 0, 12'h030, 16'h0000, 16'hABCD, 0, 2, 0, 16'h0000);
        drain();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = 16'hC000 + 16'(i / 2);
            wait_ready();
            in_req = 1'b1; in_byte = 1'b0; in_signed = 1'b0;
            in_we = ~i[0];
            in_addr = 12'h100 + 12'(i / 2 * 2);
            in_wdata = v;
            if (!i[0]) sb.push_back('{16'h0000, 1'b0, 1, cyc, 1'b1, v});
            else sb.push_back('{v, 1'b0, 2, cyc, 1'b0, 16'h0000});
        end
        @(negedge clock);
        in_req = 1'b0;
        drain();
        issue(1, 0, 0, 12'h040, 16'h5A5A, 16'h0000, 0, 1, 1, 16'h5A5A);
        drain();
        wait_ready();
        watch = 1'b1;
        in_req = 1'b1; in_we = 1'b1; in_byte = 1'b1; in_addr = 12'h041; in_wdata = 16'h0077;
        @(negedge clock);
        in_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("abort_ready", out_ready, 1);
        chk("abort_done", out_done, 0);
        chk("abort_we", out_mem_we, 0);
        chk("abort_word", out_mem_word, 0);
        chk("abort_addr_wr", out_mem_addr_wr, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        watch = 1'b0;
        chk("abort_no_write", we_seen, 0);
        issue(0, 0, 0, 12'h040, 16'h0000, 16'h5A5A, 0, 2, 0, 16'h0000);
        issue(1, 0, 0, 12'h050, 16'h4321, 16'h0000, 0, 1, 1, 16'h4321);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        issue(0, 0, 0, 12'h051, 16'h0000, 16'h0000, 1, 1, 0, 16'h0000);
`else
        issue(0, 0, 0, 12'h051, 16'h0000, 16'h4321, 0, 2, 0, 16'h0000);
`endif
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
